// File: rtl/bus_dest_regfile.sv
// bus_dest_regfile: bus destination end; captures a word plus slot code, then commits it to one of five registers.
// Optional registered read-back port enabled by defining BUS_DEST_REGFILE_READBACK_EN.
module bus_dest_regfile #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             Clock,
  input  logic             Resetn,
`ifdef BUS_DEST_REGFILE_READBACK_EN
  input  logic [2:0]       rd_sel,
  output logic [WIDTH-1:0] rd_data,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       in_sel,
  output logic [WIDTH-1:0] r0,
  output logic [WIDTH-1:0] r1,
  output logic [WIDTH-1:0] r2,
  output logic [WIDTH-1:0] r3,
  output logic [WIDTH-1:0] r4,
  output logic             wr_done,
  output logic             sel_err,
  output logic [CNT_W-1:0] wr_count
);
  typedef enum logic {IDLE, COMMIT} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [2:0]       sel_q, sel_d;
  logic [WIDTH-1:0] regs_q [5];
  logic [WIDTH-1:0] regs_d [5];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d, err_q, err_d;
`ifdef BUS_DEST_REGFILE_READBACK_EN
  logic [WIDTH-1:0] rd_q, rd_d;
  assign rd_data = rd_q;
`endif
  // Code map shared with the bus source selector: 000,111,001,010,011 -> slots 0..4
  function automatic logic sel_ok(input logic [2:0] s);
    return !(s inside {3'd4, 3'd5, 3'd6});
  endfunction
  function automatic logic [2:0] sel_idx(input logic [2:0] s);
    return s == 3'd7 ? 3'd1 : s == 3'd0 ? 3'd0 : s + 3'd1;
  endfunction
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    regs_d  = regs_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (state_q == IDLE) begin
      if (in_valid) begin
        data_d  = in_data;
        sel_d   = in_sel;
        state_d = COMMIT;
      end
    end else begin
      state_d = IDLE;
      if (sel_ok(sel_q)) begin
        regs_d[sel_idx(sel_q)] = data_q;
        cnt_d  = cnt_q + 1'b1;
        done_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
`ifdef BUS_DEST_REGFILE_READBACK_EN
    rd_d = sel_ok(rd_sel) ? regs_q[sel_idx(rd_sel)] : '0;
`endif
  end
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q <= IDLE;
      data_q  <= '0;
      sel_q   <= '0;
      regs_q  <= '{default: '0};
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef BUS_DEST_REGFILE_READBACK_EN
      rd_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      regs_q  <= regs_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef BUS_DEST_REGFILE_READBACK_EN
      rd_q    <= rd_d;
`endif
    end
  end
  assign in_ready = state_q == IDLE;
  assign r0       = regs_q[0];
  assign r1       = regs_q[1];
  assign r2       = regs_q[2];
  assign r3       = regs_q[3];
  assign r4       = regs_q[4];
  assign wr_done  = done_q;
  assign sel_err  = err_q;
  assign wr_count = cnt_q;
endmodule

// File: tb/tb_bus_dest_regfile.sv
// tb_bus_dest_regfile: directed-vector bench for bus_dest_regfile with hand-computed expectations.
module tb_bus_dest_regfile;
  logic       Clock = 1'b0, Resetn = 1'b0, in_valid = 1'b0;
  logic       in_ready, wr_done, sel_err;
  logic [7:0] in_data = 8'h00;
  logic [2:0] in_sel = 3'b000;
  logic [7:0] r0, r1, r2, r3, r4, wr_count;
`ifdef BUS_DEST_REGFILE_READBACK_EN
  logic [2:0] rd_sel = 3'b000;
  logic [7:0] rd_data;
  logic [7:0] old_r1;
`endif
  logic [7:0] exp_r [5];
  logic [7:0] exp_cnt;
  int total = 0, bad = 0;
  always #5 Clock = ~Clock;
  bus_dest_regfile dut (
    .Clock(Clock), .Resetn(Resetn),
`ifdef BUS_DEST_REGFILE_READBACK_EN
    .rd_sel(rd_sel), .rd_data(rd_data),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
    .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4),
    .wr_done(wr_done), .sel_err(sel_err), .wr_count(wr_count)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge Clock);
    #1;
  endtask
  task automatic chk_regs(input string tag);
    chk({tag, "_r0"}, r0, exp_r[0]);
    chk({tag, "_r1"}, r1, exp_r[1]);
    chk({tag, "_r2"}, r2, exp_r[2]);
    chk({tag, "_r3"}, r3, exp_r[3]);
    chk({tag, "_r4"}, r4, exp_r[4]);
    chk({tag, "_cnt"}, wr_count, exp_cnt);
  endtask
  function automatic int slot(input logic [2:0] s);
    case (s)
      3'b000:  return 0;
      3'b111:  return 1;
      3'b001:  return 2;
      3'b010:  return 3;
      3'b011:  return 4;
      default: return -1;
    endcase
  endfunction
  // Handshake (d,s) in IDLE, drive (d2,s2) during COMMIT, then check the commit result.
  task automatic xfer(input logic [7:0] d, input logic [2:0] s, input logic [7:0] d2, input logic [2:0] s2);
    int k = slot(s);
    in_valid = 1'b1;
    in_data  = d;
    in_sel   = s;
    chk("ready_idle", in_ready, 1);
    tick;
    chk("ready_commit", in_ready, 0);
    chk("done_commit", wr_done, 0);
    chk("err_commit", sel_err, 0);
    in_data = d2;
    in_sel  = s2;
    tick;
    if (k >= 0) begin
      exp_r[k] = d;
      exp_cnt  = exp_cnt + 8'd1;
    end
    chk("done", wr_done, k >= 0 ? 1 : 0);
    chk("err", sel_err, k < 0 ? 1 : 0);
    chk_regs("xfer");
  endtask
  initial begin
    for (int i = 0; i < 5; i++) exp_r[i] = 8'h00;
    exp_cnt = 8'h00;
    tick;
    tick;
    chk_regs("reset");
    chk("reset_done", wr_done, 0);
    chk("reset_err", sel_err, 0);
    Resetn = 1'b1;
    chk("reset_ready", in_ready, 1);
    xfer(8'h11, 3'b000, 8'hE1, 3'b111);
    xfer(8'h22, 3'b111, 8'hE2, 3'b001);
    xfer(8'h33, 3'b001, 8'hE3, 3'b010);
    xfer(8'h44, 3'b010, 8'hE4, 3'b011);
    xfer(8'h55, 3'b011, 8'hE5, 3'b000);
    chk("five_cnt", wr_count, 5);
    chk("five_r4", r4, 8'h55);
    xfer(8'hAA, 3'b101, 8'hBB, 3'b000);
    in_valid = 1'b0;
    tick;
    chk("err_once", sel_err, 0);
    chk("err_nodone", wr_done, 0);
    xfer(8'h66, 3'b000, 8'h77, 3'b010);
    chk("bp_r3_old", r3, 8'h44);
    xfer(8'h77, 3'b010, 8'h00, 3'b110);
    chk("bp_r3_new", r3, 8'h77);
    in_valid = 1'b0;
    tick;
    chk("bp_done_low", wr_done, 0);
    in_valid = 1'b1;
    in_data  = 8'h99;
    in_sel   = 3'b011;
    tick;
    chk("mid_commit", in_ready, 0);
    in_valid = 1'b0;
    Resetn   = 1'b0;
    tick;
    Resetn = 1'b1;
    for (int i = 0; i < 5; i++) exp_r[i] = 8'h00;
    exp_cnt = 8'h00;
    chk_regs("mid_rst");
    chk("mid_done", wr_done, 0);
    chk("mid_ready", in_ready, 1);
    tick;
    chk("mid_done_after", wr_done, 0);
    chk("mid_r4", r4, 0);
    for (int i = 0; i < 256; i++) xfer(i[7:0] ^ 8'h5A, 3'b111, 8'h00, 3'b000);
    chk("wrap_cnt", wr_count, 0);
    chk("wrap_r1", r1, 8'hA5);
    in_valid = 1'b0;
`ifdef BUS_DEST_REGFILE_READBACK_EN
    rd_sel = 3'b111;
    tick;
    chk("rd_r1", rd_data, 8'hA5);
    rd_sel = 3'b110;
    tick;
    chk("rd_invalid", rd_data, 0);
    rd_sel = 3'b000;
    tick;
    chk("rd_r0", rd_data, exp_r[0]);
    rd_sel = 3'b111;
    old_r1 = exp_r[1];
    xfer(8'h3C, 3'b111, 8'h00, 3'b000);
    chk("rd_nobypass", rd_data, old_r1);
    in_valid = 1'b0;
    tick;
    chk("rd_new", rd_data, 8'h3C);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bus_dest_regfile.md
Name: bus_dest_regfile

Overview:
- Destination end of the processor's 5-source data bus: accepts a bus word plus a 3-bit destination code and commits it into one of five holding registers.
- Uses the same code map as the bus source selector, so one code names the same slot on both ends of the bus.
- Valid/ready handshake in, one-cycle done/error pulse out, plus a wrapping count of committed writes.
- Sits between the bus driver and the datapath registers that consume bus results.

Parameters:
- WIDTH, 8, data width of the bus word and of each holding register.
- CNT_W, 8, width of the committed-write counter.

Ports:
- Clock  input  1  system clock; all state changes on rising edge.
- Resetn  input  1  synchronous, active-low reset; sampled on rising edge of Clock.
- in_valid  input  1  bus word and destination code are presented.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  WIDTH  bus word.
- in_sel  input  3  destination code: 000→R0, 111→R1, 001→R2, 010→R3, 011→R4; 100/101/110 are invalid.
- r0, r1, r2, r3, r4  output  WIDTH each  holding-register contents.
- wr_done  output  1  one-cycle pulse: a valid write committed.
- sel_err  output  1  one-cycle pulse: an accepted word had an invalid code and was dropped.
- wr_count  output  CNT_W  number of committed valid writes, modulo 2^CNT_W.

Behaviour:
- Reset, Resetn=0 at a rising edge:
  - r0..r4 = 0, wr_count = 0, wr_done = 0, sel_err = 0.
  - Capture registers cleared; FSM = IDLE.
  - in_ready = 1 from the first cycle after reset release.
- FSM has two states, IDLE and COMMIT.
- IDLE:
  - in_ready = 1.
  - Handshake (in_valid=1 and in_ready=1) at edge N: capture in_data and in_sel; go to COMMIT.
  - With no handshake, stay in IDLE.
- COMMIT (the cycle after edge N):
  - in_ready = 0; in_valid is ignored and nothing is captured.
  - At edge N+1, valid code: write the captured word into the decoded register; wr_count += 1; wr_done = 1 for the cycle after edge N+1.
  - At edge N+1, invalid code: no register changes; wr_count unchanged; sel_err = 1 for the cycle after edge N+1.
  - Always return to IDLE at edge N+1.
- Latency and throughput:
  - New register value and the done/error pulse are both visible in the cycle after edge N+1, i.e. 2 edges after the handshake.
  - Peak throughput is one word per 2 cycles.
  - Back-to-back: in_valid held high with new data is accepted on the IDLE cycle that coincides with the wr_done pulse.
- Exactly one register is written per valid commit; the other four hold their values.
- wr_done and sel_err are mutually exclusive and never high for two consecutive cycles from one word.
- wr_count wraps from 2^CNT_W−1 to 0 without a flag.
- Reset mid-operation (Resetn=0 while in COMMIT): the pending write is aborted, no pulse is produced, and all outputs take reset values.
- Resetn has priority over every other input.
- in_data/in_sel changing while in COMMIT have no effect; only the values captured at the handshake are used.

Optional Feature:
- Macro: BUS_DEST_REGFILE_READBACK_EN.
- When defined, two ports are added:
  - rd_sel  input  3  same code map as in_sel.
  - rd_data  output  WIDTH  registered read-back.
- rd_data = contents of the register selected by rd_sel at edge M, visible after edge M (1-cycle latency).
- Invalid rd_sel gives 0. rd_data resets to 0.
- Same-cycle read and commit to the same register returns the old value (no bypass).
- When undefined: rd_sel and rd_data do not exist; all other behaviour is identical.

Test Plan:
- Reset then idle: hold Resetn=0 for 2 edges, release -> r0..r4=0, wr_count=0, in_ready=1, no pulses.
- Write each slot: send 0x11 sel 000, 0x22 sel 111, 0x33 sel 001, 0x44 sel 010, 0x55 sel 011 with in_valid held -> r0=11, r1=22, r2=33, r3=44, r4=55; five wr_done pulses, 2 cycles apart; wr_count=5.
- Invalid code: send 0xAA sel 101 -> sel_err pulses once 2 edges after handshake; r0..r4 unchanged; wr_count unchanged; no wr_done.
- Backpressure: present 0x66 sel 000, then change to 0x77 sel 010 during COMMIT -> in_ready=0 in COMMIT; r0=66; the 0x77 word is accepted only on the next IDLE cycle, then r3=77.
- Reset mid-operation: handshake 0x99 sel 011, assert Resetn=0 in the COMMIT cycle -> r4=0, no wr_done, wr_count=0.
- Counter wrap and readback (macro defined): 256 valid writes -> wr_count returns to 0; after the last write, rd_sel=111 -> rd_data=r1 one edge later; rd_sel=110 -> rd_data=0.
